seg7_scan_ctrl: RTL

Multiplexed 7-segment display controller. It time-shares one hex-to-segment decoder across `NUM_DIGITS` common-anode digits. It holds a small digit register file written by the host, and scans digits at a fixed prescaled rate with a guard interval per slot to suppress ghosting. It sits between board-level control logic and the 7-segment pins (a..g, dp, digit enables).

---
 rtl/seg7_pkg.sv | 36 +++
 rtl/seg7_decode.sv | 39 +++
 rtl/seg7_scan_ctrl.sv | 164 ++++++++++++++++
 3 files changed

// File: rtl/seg7_pkg.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_pkg: scan states, hex segment patterns, off-level helper     |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
package seg7_pkg;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_GUARD = 2'd1;
   localparam logic [1:0] ST_DRIVE = 2'd2;

   // Active-high a..g patterns, seg[6]=a .. seg[0]=g
   localparam logic [6:0] SEG_0     = 7'h7E;
   localparam logic [6:0] SEG_1     = 7'h30;
   localparam logic [6:0] SEG_2     = 7'h6D;
   localparam logic [6:0] SEG_3     = 7'h79;
   localparam logic [6:0] SEG_4     = 7'h33;
   localparam logic [6:0] SEG_5     = 7'h5B;
   localparam logic [6:0] SEG_6     = 7'h5F;
   localparam logic [6:0] SEG_7     = 7'h70;
   localparam logic [6:0] SEG_8     = 7'h7F;
   localparam logic [6:0] SEG_9     = 7'h7B;
   localparam logic [6:0] SEG_A     = 7'h77;
   localparam logic [6:0] SEG_B     = 7'h1F;
   localparam logic [6:0] SEG_C     = 7'h4E;
   localparam logic [6:0] SEG_D     = 7'h3D;
   localparam logic [6:0] SEG_E     = 7'h4F;
   localparam logic [6:0] SEG_F     = 7'h47;
   localparam logic [6:0] SEG_BLANK = 7'h00;

   function automatic logic off_level(input bit active_low);
      return active_low;
   endfunction

endpackage
`default_nettype wire

// File: rtl/seg7_decode.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_decode: 4-bit hex + blank -> active-high a..g pattern        |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seg7_decode
   import seg7_pkg::*;
(
   input  logic [3:0] value,
   input  logic       blank,
   output logic [6:0] pattern
);

   always_comb begin
      pattern = SEG_BLANK;
      if (!blank) begin
         case (value)
            4'h0: pattern = SEG_0;
            4'h1: pattern = SEG_1;
            4'h2: pattern = SEG_2;
            4'h3: pattern = SEG_3;
            4'h4: pattern = SEG_4;
            4'h5: pattern = SEG_5;
            4'h6: pattern = SEG_6;
            4'h7: pattern = SEG_7;
            4'h8: pattern = SEG_8;
            4'h9: pattern = SEG_9;
            4'hA: pattern = SEG_A;
            4'hB: pattern = SEG_B;
            4'hC: pattern = SEG_C;
            4'hD: pattern = SEG_D;
            4'hE: pattern = SEG_E;
            default: pattern = SEG_F;
         endcase
      end
   end

endmodule
`default_nettype wire

// File: rtl/seg7_scan_ctrl.sv
`default_nettype none
// +------------------------------------------------------------------+
// | seg7_scan_ctrl: multiplexed 7-segment scanner with guard interval |
// | Rev 1.0                                                          |
// +------------------------------------------------------------------+
module seg7_scan_ctrl
   import seg7_pkg::*;
#(
   parameter int NUM_DIGITS = 4,
   parameter int TICK_DIV   = 50000,
   parameter int GUARD      = 2,
   parameter int ACTIVE_LOW = 1,
   localparam int AW        = (NUM_DIGITS > 1) ? $clog2(NUM_DIGITS) : 1
)(
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic                  enable,
   input  logic                  wr_en,
   input  logic [AW-1:0]         wr_addr,
   input  logic [3:0]            wr_data,
   input  logic                  wr_dp,
   input  logic                  blank_lz,
   output logic [6:0]            seg,
   output logic                  dp,
   output logic [NUM_DIGITS-1:0] digit_sel,
   output logic                  frame_done
);

   localparam int              CW        = $clog2(TICK_DIV);
   localparam logic [AW-1:0]   LAST_IDX  = AW'(NUM_DIGITS - 1);
   localparam logic [CW-1:0]   GUARD_END = CW'(GUARD - 1);
   localparam logic [CW-1:0]   SLOT_END  = CW'(TICK_DIV - 1);
   localparam logic            OFF       = off_level(ACTIVE_LOW != 0);

   logic [1:0]            state_q, state_d;
   logic [AW-1:0]         idx_q, idx_d;
   logic [CW-1:0]         cnt_q, cnt_d;
   logic [3:0]            value_q [NUM_DIGITS];
   logic [3:0]            value_d [NUM_DIGITS];
   logic [NUM_DIGITS-1:0] dpreg_q, dpreg_d;
   logic [6:0]            seg_q, seg_d;
   logic                  dp_q, dp_d;
   logic [NUM_DIGITS-1:0] sel_q, sel_d;
   logic                  frame_q, frame_d;

   logic [AW-1:0]         lat_idx;
   logic                  lat_blank;
   logic                  all_zero;
   logic [6:0]            lat_pattern;
   logic                  load;

   // The digit about to be latched: 0 when starting from IDLE, else the successor
   assign lat_idx = (state_q == ST_DRIVE && idx_q != LAST_IDX) ? idx_q + AW'(1) : '0;

   always_comb begin
      all_zero = 1'b1;
      for (int k = 0; k < NUM_DIGITS; k++) begin
         if (k >= int'(lat_idx) && value_q[k] != 4'd0) all_zero = 1'b0;
      end
      lat_blank = blank_lz && all_zero && (lat_idx != '0);
   end

   seg7_decode u_decode (
      .value   (value_q[lat_idx]),
      .blank   (lat_blank),
      .pattern (lat_pattern)
   );

   always_comb begin
      state_d = state_q;
      idx_d   = idx_q;
      cnt_d   = cnt_q;
      value_d = value_q;
      dpreg_d = dpreg_q;
      seg_d   = seg_q;
      dp_d    = dp_q;
      sel_d   = sel_q;
      frame_d = 1'b0;
      load    = 1'b0;

      if (wr_en && int'(wr_addr) < NUM_DIGITS) begin
         value_d[wr_addr] = wr_data;
         dpreg_d[wr_addr] = wr_dp;
      end

      case (state_q)
         ST_IDLE: begin
            if (enable) begin
               state_d = ST_GUARD;
               idx_d   = '0;
               cnt_d   = '0;
               load    = 1'b1;
            end
         end
         ST_GUARD: begin
            cnt_d = cnt_q + CW'(1);
            if (cnt_q == GUARD_END) begin
               state_d = ST_DRIVE;
               sel_d   = (NUM_DIGITS'(1) << idx_q) ^ {NUM_DIGITS{OFF}};
            end
         end
         ST_DRIVE: begin
            if (cnt_q == SLOT_END) begin
               state_d = ST_GUARD;
               cnt_d   = '0;
               idx_d   = lat_idx;
               sel_d   = {NUM_DIGITS{OFF}};
               frame_d = (idx_q == LAST_IDX);
               load    = 1'b1;
            end else begin
               cnt_d = cnt_q + CW'(1);
            end
         end
         default: state_d = ST_IDLE;
      endcase

      // Register-file reads see pre-write contents, so same-cycle writes wait a frame
      if (load) begin
         seg_d = lat_pattern ^ {7{OFF}};
         dp_d  = dpreg_q[lat_idx] ^ OFF;
      end

      if (!enable) begin
         state_d = ST_IDLE;
         idx_d   = '0;
         cnt_d   = '0;
         seg_d   = {7{OFF}};
         dp_d    = OFF;
         sel_d   = {NUM_DIGITS{OFF}};
         frame_d = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q <= ST_IDLE;
         idx_q   <= '0;
         cnt_q   <= '0;
         value_q <= '{default: '0};
         dpreg_q <= '0;
         seg_q   <= {7{OFF}};
         dp_q    <= OFF;
         sel_q   <= {NUM_DIGITS{OFF}};
         frame_q <= 1'b0;
      end else begin
         state_q <= state_d;
         idx_q   <= idx_d;
         cnt_q   <= cnt_d;
         value_q <= value_d;
         dpreg_q <= dpreg_d;
         seg_q   <= seg_d;
         dp_q    <= dp_d;
         sel_q   <= sel_d;
         frame_q <= frame_d;
      end
   end

   assign seg        = seg_q;
   assign dp         = dp_q;
   assign digit_sel  = sel_q;
   assign frame_done = frame_q;

endmodule
`default_nettype wire
